// File: rtl/demux_1_to_4_buf_if.sv
// Handshake bundle between a source, the 1-to-4 demux and its four sinks.
// Master is the source/sink side of the bench or fabric; slave is the demux itself.
interface demux_1_to_4_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sel;
    logic [DATA_WIDTH-1:0] in_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic [DATA_WIDTH-1:0] out3;
    logic [DATA_WIDTH-1:0] out4;
    logic [1:0]            count;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out1, out2, out3, out4, count
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out1, out2, out3, out4, count
    );
endinterface

// File: rtl/demux_1_to_4_buf.sv
// Purpose: steers each buffered source word to one of four sinks chosen by its select.
// Latency: 1 cycle from push to out_valid; no combinational bypass.
// Backpressure: 2-entry FIFO; in_ready = not full, strict order, head-of-line blocking.
module demux_1_to_4_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1_to_4_buf_if.slave    bus
);
    typedef struct packed {
        logic [1:0]            sel;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t     mem [DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] cnt;

    entry_t     head;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    assign head  = mem[rd_ptr];
    assign full  = (cnt == 2'(DEPTH));
    assign empty = (cnt == 2'd0);

    // in_ready depends on occupancy only, so a full buffer stays closed during a pop.
    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready[head.sel];

    assign bus.in_ready = !full;
    assign bus.count    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{sel: bus.in_sel, data: bus.in_data};
        end
    end

    always_comb begin
        bus.out_valid = 4'b0000;
        bus.out1      = '0;
        bus.out2      = '0;
        bus.out3      = '0;
        bus.out4      = '0;
        if (!empty) begin
            bus.out_valid = 4'b0001 << head.sel;
            case (head.sel)
                2'd0:    bus.out1 = head.data;
                2'd1:    bus.out2 = head.data;
                2'd2:    bus.out3 = head.data;
                default: bus.out4 = head.data;
            endcase
        end
    end
endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Directed vector table plus hand-written sequences for random traffic and mid-transfer reset.
module tb_demux_1_to_4_buf;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    demux_1_to_4_buf_if #(.DATA_WIDTH(32)) bus ();

    demux_1_to_4_buf #(.DATA_WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [31:0] dat;
        logic [3:0]  ordy;
        logic [3:0]  ev;
        logic [1:0]  ec;
        logic        eir;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } word_t;

    vec_t  vt [25];
    word_t mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] ev, input logic [1:0] ec,
                            input logic eir, input logic [31:0] ed);
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({name, ".count"},     32'(bus.count),     32'(ec));
        chk({name, ".in_ready"},  32'(bus.in_ready),  32'(eir));
        chk({name, ".out1"}, bus.out1, ev[0] ? ed : 32'h0);
        chk({name, ".out2"}, bus.out2, ev[1] ? ed : 32'h0);
        chk({name, ".out3"}, bus.out3, ev[2] ? ed : 32'h0);
        chk({name, ".out4"}, bus.out4, ev[3] ? ed : 32'h0);
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [31:0] dat,
                         input logic [3:0] ordy);
        bus.in_valid  = iv;
        bus.in_sel    = sel;
        bus.in_data   = dat;
        bus.out_ready = ordy;
    endtask

    initial begin
        // Each row: inputs held this cycle; outputs expected before the closing edge.
        vt[0]  = '{1'b0, 2'd0, 32'h0,        4'hf, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[1]  = '{1'b0, 2'd0, 32'h0,        4'hf, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 2'd0, 32'h11111111, 4'hf, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[3]  = '{1'b1, 2'd2, 32'h33333333, 4'hf, 4'b0001, 2'd1, 1'b1, 32'h11111111};
        vt[4]  = '{1'b0, 2'd0, 32'h0,        4'hf, 4'b0100, 2'd1, 1'b1, 32'h33333333};
        vt[5]  = '{1'b0, 2'd0, 32'h0,        4'h0, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 2'd1, 32'h0000000a, 4'h0, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 2'd3, 32'h0000000b, 4'h0, 4'b0010, 2'd1, 1'b1, 32'h0000000a};
        for (int i = 8; i <= 12; i++)
            vt[i] = '{1'b1, 2'd0, 32'hdeadbeef, 4'h0, 4'b0010, 2'd2, 1'b0, 32'h0000000a};
        vt[13] = '{1'b0, 2'd0, 32'h0,        4'b0010, 4'b0010, 2'd2, 1'b0, 32'h0000000a};
        vt[14] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b1000, 2'd1, 1'b1, 32'h0000000b};
        vt[15] = '{1'b0, 2'd0, 32'h0,        4'b1000, 4'b1000, 2'd1, 1'b1, 32'h0000000b};
        vt[16] = '{1'b1, 2'd2, 32'h00000077, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[17] = '{1'b0, 2'd0, 32'h0,        4'b1011, 4'b0100, 2'd1, 1'b1, 32'h00000077};
        vt[18] = '{1'b0, 2'd0, 32'h0,        4'b1011, 4'b0100, 2'd1, 1'b1, 32'h00000077};
        vt[19] = '{1'b0, 2'd0, 32'h0,        4'b0100, 4'b0100, 2'd1, 1'b1, 32'h00000077};
        vt[20] = '{1'b1, 2'd0, 32'h00000099, 4'b0000, 4'b0000, 2'd0, 1'b1, 32'h0};
        vt[21] = '{1'b1, 2'd3, 32'h0000000c, 4'b0001, 4'b0001, 2'd1, 1'b1, 32'h00000099};
        vt[22] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b1000, 2'd1, 1'b1, 32'h0000000c};
        vt[23] = '{1'b0, 2'd0, 32'h0,        4'b1000, 4'b1000, 2'd1, 1'b1, 32'h0000000c};
        vt[24] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0000, 2'd0, 1'b1, 32'h0};

        n_cmp = 0;
        n_err = 0;
        drive(1'b0, 2'd0, 32'h0, 4'hf);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 4'b0000, 2'd0, 1'b1, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].iv, vt[i].sel, vt[i].dat, vt[i].ordy);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vt[i].ev, vt[i].ec, vt[i].eir, vt[i].ed);
            @(posedge clk);
            #1;
        end

        // Random traffic against a queue model; crosses pointer wrap many times.
        mq.delete();
        for (int i = 0; i < 60; i++) begin
            logic        iv;
            logic [1:0]  sel;
            logic [31:0] dat;
            logic [3:0]  ordy;
            logic [3:0]  ev;
            logic [31:0] ed;
            logic        eir;
            logic        do_pop;
            iv   = (i < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
            sel  = 2'($urandom_range(0, 3));
            dat  = 32'h1000 + 32'(i);
            ordy = (i < 50) ? 4'($urandom_range(0, 15)) : 4'hf;
            drive(iv, sel, dat, ordy);
            ev  = (mq.size() != 0) ? (4'b0001 << mq[0].sel) : 4'b0000;
            ed  = (mq.size() != 0) ? mq[0].data : 32'h0;
            eir = (mq.size() != 2);
            @(negedge clk);
            chk_outs($sformatf("rnd%0d", i), ev, 2'(mq.size()), eir, ed);
            do_pop = (mq.size() != 0) && ordy[mq[0].sel];
            if (do_pop) void'(mq.pop_front());
            if (iv && eir) mq.push_back('{sel, dat});
            @(posedge clk);
            #1;
        end
        chk("rnd_drained", 32'(mq.size()), 32'd0);

        // Fill to two entries, then reset between edges.
        drive(1'b1, 2'd2, 32'h0000aaaa, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 32'h0000bbbb, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        @(negedge clk);
        chk_outs("pre_rst", 4'b0100, 2'd2, 1'b0, 32'h0000aaaa);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 4'b0000, 2'd0, 1'b1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 32'h00000005, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        @(negedge clk);
        chk_outs("post_rst", 4'b0010, 2'd1, 1'b1, 32'h00000005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
